// File: rtl/mem_port_arbiter_pkg.sv
// Encodings shared by the unified memory port arbiter and the control decoder.
// Covers FSM states, port owner and the byte-enable patterns for byte/half/word accesses.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  function automatic owner_e owner_of(input arb_state_e s);
    return (s == BUSY_D) ? OWN_D : OWN_I;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_timer.sv
// Timeout counter for an outstanding memory transaction.
// Clear dominates enable; tc is high while the count equals TIMEOUT-1.
module mem_port_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int W = $clog2(TIMEOUT);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the I-fetch and D-access ports onto one single-ported memory; D has priority with a bounded streak.
// Request seen in IDLE -> mem_req next cycle -> owner ack/err the cycle after mem_ack (or timeout).
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic                i_kill,
  output logic                i_ack,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_stall,
  output logic                i_err,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_stall,
  output logic                d_err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int BE_W = DATA_W / 8;
  localparam int SW   = $clog2(MAX_D_STREAK + 1);

  arb_state_e        state_q, state_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic              kill_q, kill_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              i_ack_q, i_ack_d, i_err_q, i_err_d;
  logic              d_ack_q, d_ack_d, d_err_q, d_err_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic              i_elig, streak_max, killed, busy, timer_tc;

  assign i_elig     = i_req & ~i_kill;
  assign streak_max = (streak_q == SW'(MAX_D_STREAK));
  assign killed     = kill_q | i_kill;
  assign busy       = (state_q == BUSY_I) || (state_q == BUSY_D);

  mem_port_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk_i (CLK),
    .rst_i (RST),
    .clr_i (state_q == IDLE),
    .en_i  (busy),
    .tc_o  (timer_tc)
  );

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    kill_d      = kill_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    i_ack_d     = 1'b0;
    i_err_d     = 1'b0;
    d_ack_d     = 1'b0;
    d_err_d     = 1'b0;
    i_rdata_d   = '0;
    d_rdata_d   = '0;
    case (state_q)
      IDLE: begin
        kill_d = 1'b0;
        if (d_req && !(i_elig && streak_max)) begin
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_be_d    = d_be;
          mem_wdata_d = d_wdata;
          // Only D wins that starve a waiting fetch count toward the streak.
          if (i_elig) begin
            streak_d = streak_max ? streak_q : streak_q + SW'(1);
          end else begin
            streak_d = '0;
          end
        end else if (i_elig) begin
          state_d     = BUSY_I;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = i_addr;
          mem_be_d    = '1;
          mem_wdata_d = '0;
          streak_d    = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (state_q == BUSY_I && i_kill) begin
          kill_d = 1'b1;
        end
        if (mem_ack || timer_tc) begin
          mem_req_d = 1'b0;
          state_d   = RESP;
          if (owner_of(state_q) == OWN_D) begin
            d_ack_d   = mem_ack;
            d_err_d   = ~mem_ack;
            d_rdata_d = mem_ack ? mem_rdata : '0;
          end else if (!killed) begin
            i_ack_d   = mem_ack;
            i_err_d   = ~mem_ack;
            i_rdata_d = mem_ack ? mem_rdata : '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        kill_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      kill_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      i_ack_q     <= 1'b0;
      i_err_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      d_err_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      kill_q      <= kill_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      i_ack_q     <= i_ack_d;
      i_err_q     <= i_err_d;
      d_ack_q     <= d_ack_d;
      d_err_q     <= d_err_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign i_ack     = i_ack_q;
  assign i_err     = i_err_q;
  assign i_rdata   = i_rdata_q;
  assign d_ack     = d_ack_q;
  assign d_err     = d_err_q;
  assign d_rdata   = d_rdata_q;
  assign i_stall   = i_req & ~i_ack_q;
  assign d_stall   = d_req & ~d_ack_q;

endmodule
